// File: rtl/tt_um_sum_accum.sv
// tt_um_sum_accum: strobed 16-bit byte accumulator with add count, sticky overflow and update pulse.
// Define SUM_ACCUM_SATURATE_EN to clamp acc at 16'hFFFF instead of wrapping.
module tt_um_sum_accum #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  typedef enum logic [1:0] {IDLE, ADD, ACK} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic [15:0] acc_q, acc_d, acc_sum;
  logic [3:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, upd_q, upd_d, prev_q, prev_d, pend_q, pend_d;
  logic strb_s, clr_s, sel_s, add_req, go;
  logic [16:0] sum;
  logic unused_ok;
  assign unused_ok = &{ena, uio_in[7:3]};
  assign {sel_s, clr_s, strb_s} = sync_q[SYNC_STAGES-1];
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], uio_in[2:0]};
    add_req = strb_s & ~prev_q;
    go = (state_q == IDLE) & (add_req | pend_q);
    sum = {1'b0, acc_q} + {9'h000, ui_in};
`ifdef SUM_ACCUM_SATURATE_EN
    acc_sum = sum[16] ? 16'hFFFF : sum[15:0];
`else
    acc_sum = sum[15:0];
`endif
    prev_d = strb_s;
    state_d = clr_s ? IDLE : go ? ADD : (state_q == ADD) ? ACK : IDLE;
    acc_d = clr_s ? 16'h0000 : go ? acc_sum : acc_q;
    cnt_d = clr_s ? 4'd0 : (go && cnt_q != 4'd15) ? cnt_q + 4'd1 : cnt_q;
    ovf_d = ~clr_s & (ovf_q | (go & sum[16]));
    upd_d = ~clr_s & (state_q == ADD);
    // strobe rises while busy are remembered and serviced on return to IDLE
    pend_d = ~clr_s & (state_q != IDLE) & (pend_q | add_req);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      state_q <= IDLE;
      acc_q <= 16'h0000;
      cnt_q <= 4'd0;
      ovf_q <= 1'b0;
      upd_q <= 1'b0;
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      state_q <= state_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      upd_q <= upd_d;
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end
  assign uo_out = sel_s ? acc_q[15:8] : acc_q[7:0];
  assign uio_out = {ovf_q, cnt_q == 4'd15, upd_q, sel_s, 4'h0};
  assign uio_oe = 8'hF0;
endmodule

// File: tb/tb_tt_um_sum_accum.sv
// tb_tt_um_sum_accum: directed and random strobe sequences checked against an arithmetic accumulator model.
module tb_tt_um_sum_accum;
  logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int checks = 0, failures = 0, upd_cnt = 0, upd_wide = 0;
  bit upd_prev = 1'b0;
  int m_acc = 0, m_cnt = 0;
  bit m_ovf = 1'b0;

  tt_um_sum_accum #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (uio_out[5]) begin
      upd_cnt++;
      if (upd_prev) upd_wide++;
    end
    upd_prev = uio_out[5];
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_add(input int v);
    m_acc += v;
    if (m_acc > 65535) begin
      m_ovf = 1'b1;
`ifdef SUM_ACCUM_SATURATE_EN
      m_acc = 65535;
`else
      m_acc -= 65536;
`endif
    end
    m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
  endtask

  task automatic model_zero();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic do_add(input int v);
    int u0, t;
    u0 = upd_cnt;
    t = 0;
    ui_in = v[7:0];
    uio_in[0] = 1'b1;
    while (upd_cnt == u0 && t < 30) begin
      cyc(1);
      t++;
    end
    uio_in[0] = 1'b0;
    cyc(3);
    chk("upd_once", upd_cnt - u0, 1);
    model_add(v);
  endtask

  task automatic check_state(input string tag);
    uio_in[2] = 1'b0;
    cyc(4);
    chk({tag, "_lo"}, int'(uo_out), m_acc & 255);
    chk({tag, "_ovf"}, int'(uio_out[7]), int'(m_ovf));
    chk({tag, "_full"}, int'(uio_out[6]), int'(m_cnt == 15));
    chk({tag, "_sel0"}, int'(uio_out[4]), 0);
    uio_in[2] = 1'b1;
    cyc(4);
    chk({tag, "_hi"}, int'(uo_out), (m_acc >> 8) & 255);
    chk({tag, "_sel1"}, int'(uio_out[4]), 1);
    uio_in[2] = 1'b0;
    cyc(4);
  endtask

  task automatic do_clear();
    uio_in[1] = 1'b1;
    cyc(5);
    chk("clr_hold", int'(uo_out), 0);
    uio_in[1] = 1'b0;
    cyc(4);
    model_zero();
  endtask

  initial begin
    int u0;
    #1;
    chk("rst_uo", int'(uo_out), 0);
    chk("rst_uio", int'(uio_out), 0);
    chk("rst_oe", int'(uio_oe), 'hF0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    // first add doubles as a latency check: visible two edges after strobe sampling
    ui_in = 8'h10;
    uio_in[0] = 1'b1;
    cyc(2);
    chk("lat_early", int'(uo_out), 0);
    cyc(1);
    chk("lat_n2", int'(uo_out), 'h10);
    cyc(4);
    uio_in[0] = 1'b0;
    cyc(2);
    model_add('h10);
    do_add('h20);
    do_add('h30);
    check_state("basic");
    chk("basic_cnt3_notfull", int'(uio_out[6]), 0);
    do_clear();
    for (int i = 0; i < 10; i++) begin
      do_add(int'($urandom_range(0, 255)));
      check_state("rand");
    end
    do_clear();
    for (int i = 1; i <= 17; i++) begin
      do_add(1);
      chk("cnt_full_seq", int'(uio_out[6]), int'(i >= 15));
    end
    check_state("seventeen");
    do_clear();
    u0 = upd_cnt;
    ui_in = 8'h05;
    uio_in[0] = 1'b1;
    cyc(1);
    uio_in[0] = 1'b0;
    cyc(1);
    uio_in[0] = 1'b1;
    cyc(1);
    ui_in = 8'h07;
    cyc(10);
    uio_in[0] = 1'b0;
    cyc(3);
    chk("pend_upd2", upd_cnt - u0, 2);
    model_add(5);
    model_add(7);
    check_state("pending");
    do_clear();
    while (m_acc + 255 <= 'hFFF0) do_add(255);
    do_add('hFFF0 - m_acc);
    check_state("near_top");
    do_add('h20);
    check_state("overflow");
    u0 = upd_cnt;
    ui_in = 8'h44;
    uio_in[1] = 1'b1;
    uio_in[0] = 1'b1;
    cyc(8);
    chk("clr_add_upd", upd_cnt - u0, 0);
    chk("clr_add_acc", int'(uo_out), 0);
    chk("clr_add_ovf", int'(uio_out[7]), 0);
    uio_in[1] = 1'b0;
    cyc(8);
    chk("clr_rel_upd", upd_cnt - u0, 0);
    model_zero();
    check_state("clr_release");
    uio_in[0] = 1'b0;
    cyc(2);
    do_add('h50);
    ui_in = 8'h33;
    uio_in[0] = 1'b1;
    cyc(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_uo", int'(uo_out), 0);
    chk("rst_mid_uio", int'(uio_out), 0);
    chk("rst_mid_oe", int'(uio_oe), 'hF0);
    uio_in[0] = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    model_zero();
    cyc(4);
    do_add('h09);
    check_state("after_rst");
    chk("upd_width", upd_wide, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
